apb_master_bridge: RTL and testbench

- Upstream APB requester that drives the mem_block register bank: accepts single read/write commands on a valid/ready command port and runs a full APB SETUP/ACCESS transfer on sel/enable/wr/addr/wdata.
- Waits for the slave's ready, captures rdata on reads, and returns a response on a valid/ready response port.
- Bounded wait: aborts with an error if ready never arrives.

---
 rtl/apb_master_bridge.sv | 141 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into APB SETUP/ACCESS transfers
// and returns read data or a timeout error on a valid/ready response port.
module apb_master_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sel,
  output logic                  enable,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata
);

  // Keep a one-bit counter when the timeout is disabled so widths stay legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  sel_nxt, enable_nxt, wr_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic                  rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

  assign cmd_ready = (state == IDLE);

  // NOTE: every next-value signal takes its current value first, so a path
  // that assigns nothing holds the register instead of inferring a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sel_nxt       = sel;
    enable_nxt    = enable;
    wr_nxt        = wr;
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          wr_nxt    = cmd_wr;
          addr_nxt  = cmd_addr;
          wdata_nxt = cmd_wr ? cmd_wdata : '0;
          sel_nxt   = 1'b1;
          state_nxt = SETUP;
        end
      end

      SETUP: begin
        enable_nxt = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = ACCESS;
      end

      ACCESS: begin
        // Ready is checked first so a late ready on the limit edge still succeeds.
        if (ready) begin
          sel_nxt       = 1'b0;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = wr ? '0 : rdata;
          state_nxt     = RESP;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          sel_nxt       = 1'b0;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
          state_nxt     = RESP;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      enable    <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      enable    <= enable_nxt;
      wr        <= wr_nxt;
      addr      <= addr_nxt;
      wdata     <= wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge against a behavioural APB memory slave
// with programmable wait states, stuck-ready mode and read-data override.
module tb_apb_master_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_wr = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       sel, enable, wr;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic [7:0] rdata;

  apb_master_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sel       (sel),
    .enable    (enable),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  // Behavioural slave: 32 x 8 memory reset to 8'haa, shares the bridge reset.
  logic [7:0] mem [32];
  int         wait_n   = 0;
  int         acc_wait = 0;
  bit         stuck    = 1'b0;
  bit         ovr      = 1'b0;
  logic [7:0] ovr_data = 8'h00;

  assign ready = sel && enable && !stuck && (acc_wait >= wait_n);
  assign rdata = ovr ? ovr_data : mem[addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'haa;
      acc_wait <= 0;
    end else begin
      if (sel && enable && ready && wr) mem[addr] <= wdata;
      acc_wait <= (sel && enable && !ready) ? acc_wait + 1 : 0;
    end
  end

  // Checking and scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Present a command, wait (bounded) for acceptance, optionally log the expected response.
  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d,
                      input logic [7:0] er, input logic ee, input bit expect_rsp);
    bit ok = 1'b0;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (expect_rsp) begin
      rsp_t e;
      e.rdata = er;
      e.err   = ee;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_rsp();
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("rsp_arrived", 32'(done), 32'd1);
  endtask

  // Count enable-high cycles and addr instability until rsp_valid rises.
  task automatic watch_access(input logic [4:0] a, output int en_cnt, output int addr_bad);
    en_cnt   = 0;
    addr_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (enable) en_cnt++;
      if (sel && addr !== a) addr_bad++;
    end
  endtask

  int en_cnt, addr_bad;

  initial begin
    // Reset state
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    #14;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait write with cycle-level timing
    send(1'b1, 5'h03, 8'hbb, 8'h00, 1'b0, 1'b1);
    check("wr_n_sel", 32'(sel), 32'd1);
    check("wr_n_enable", 32'(enable), 32'd0);
    check("wr_n_wr", 32'(wr), 32'd1);
    check("wr_n_addr", 32'(addr), 32'h03);
    check("wr_n_wdata", 32'(wdata), 32'hbb);
    check("wr_n_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check("wr_n1_sel", 32'(sel), 32'd1);
    check("wr_n1_enable", 32'(enable), 32'd1);
    @(posedge clk);
    #1;
    check("wr_n2_sel", 32'(sel), 32'd0);
    check("wr_n2_enable", 32'(enable), 32'd0);
    check("wr_n2_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_rsp();

    // Readback and unwritten location
    send(1'b0, 5'h03, 8'h77, 8'hbb, 1'b0, 1'b1);
    check("rd_wdata_zero", 32'(wdata), 32'd0);
    check("rd_wr_low", 32'(wr), 32'd0);
    wait_rsp();
    send(1'b0, 5'h07, 8'h00, 8'haa, 1'b0, 1'b1);
    wait_rsp();

    // Three wait states with overridden read data
    wait_n   = 3;
    ovr      = 1'b1;
    ovr_data = 8'h5c;
    send(1'b0, 5'h11, 8'h00, 8'h5c, 1'b0, 1'b1);
    watch_access(5'h11, en_cnt, addr_bad);
    check("ws_enable_cycles", 32'(en_cnt), 32'd4);
    check("ws_addr_stable", 32'(addr_bad), 32'd0);
    wait_rsp();
    wait_n = 0;
    ovr    = 1'b0;

    // Timeout with ready stuck low
    stuck = 1'b1;
    send(1'b0, 5'h05, 8'h00, 8'h00, 1'b1, 1'b1);
    watch_access(5'h05, en_cnt, addr_bad);
    check("to_enable_cycles", 32'(en_cnt), 32'd16);
    check("to_sel_low", 32'(sel), 32'd0);
    check("to_enable_low", 32'(enable), 32'd0);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_rsp();
    stuck = 1'b0;
    send(1'b0, 5'h03, 8'h00, 8'hbb, 1'b0, 1'b1);
    wait_rsp();

    // Response backpressure with a queued write behind it
    rsp_ready = 1'b0;
    send(1'b0, 5'h03, 8'h00, 8'hbb, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    cmd_wr    = 1'b1;
    cmd_addr  = 5'h0f;
    cmd_wdata = 8'hca;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'hbb);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_sel", 32'(sel), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    begin
      rsp_t e;
      e.rdata = 8'h00;
      e.err   = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("b2b_sel", 32'(sel), 32'd1);
    check("b2b_addr", 32'(addr), 32'h0f);
    check("b2b_wdata", 32'(wdata), 32'hca);
    wait_rsp();
    send(1'b0, 5'h0f, 8'h00, 8'hca, 1'b0, 1'b1);
    wait_rsp();

    // Asynchronous reset in the middle of ACCESS
    stuck = 1'b1;
    send(1'b0, 5'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_enable_high", 32'(enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_enable", 32'(enable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    stuck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    send(1'b0, 5'h03, 8'h00, 8'haa, 1'b0, 1'b1);
    wait_rsp();

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
